reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 183 ++++++++++++++++++
 tb/tb_reservation_station.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both operand tags are
// resolved by result broadcasts, then issues the lowest-index ready entry to the ALU.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 5,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             enable_sign_from_cmd,
  input  logic [OP_W-1:0]  opnum_from_cmd,
  input  logic [31:0]      V1_from_cmd,
  input  logic [31:0]      V2_from_cmd,
  input  logic [ROB_W-1:0] Q1_from_cmd,
  input  logic [ROB_W-1:0] Q2_from_cmd,
  input  logic [31:0]      pc_from_cmd,
  input  logic [31:0]      imm_from_cmd,
  input  logic [ROB_W-1:0] rob_id_from_cmd,
  input  logic             valid_sign_from_rs_ex,
  input  logic [ROB_W-1:0] rob_id_from_rs_ex,
  input  logic [31:0]      data_from_rs_ex,
  input  logic             valid_sign_from_ls_ex,
  input  logic [ROB_W-1:0] rob_id_from_ls_ex,
  input  logic [31:0]      data_from_ls_ex,
  input  logic             rollback_sign_from_rob,
  output logic             full_sign_to_fch,
  output logic             enable_sign_to_rs_ex,
  output logic [OP_W-1:0]  opnum_to_rs_ex,
  output logic [31:0]      V1_to_rs_ex,
  output logic [31:0]      V2_to_rs_ex,
  output logic [31:0]      pc_to_rs_ex,
  output logic [31:0]      imm_to_rs_ex,
  output logic [ROB_W-1:0] rob_id_to_rs_ex
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(RS_SIZE);
  localparam int CNT_W  = IDX_W + 1;

  logic [RS_SIZE-1:0] busy;
  logic [ROB_W-1:0]   q1 [RS_SIZE];
  logic [ROB_W-1:0]   q2 [RS_SIZE];
  logic [OP_W-1:0]    op [RS_SIZE];
  logic [DATA_W-1:0]  v1 [RS_SIZE];
  logic [DATA_W-1:0]  v2 [RS_SIZE];
  logic [DATA_W-1:0]  pc [RS_SIZE];
  logic [DATA_W-1:0]  imm [RS_SIZE];
  logic [ROB_W-1:0]   rob [RS_SIZE];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             iss_found;
  logic [IDX_W-1:0] iss_idx;
  logic [CNT_W-1:0] busy_cnt;
  logic             advance;
  logic             do_insert;

  // A broadcast with rob id 0 carries no tag and must never match.
  function automatic logic bus_hit(input logic [ROB_W-1:0] tag, input logic vld,
                                   input logic [ROB_W-1:0] id);
    return vld && (id != '0) && (tag == id);
  endfunction

  // The ALU bus wins when both buses carry the same tag.
  function automatic logic [DATA_W-1:0] fwd_val(input logic [ROB_W-1:0] tag,
                                                input logic [DATA_W-1:0] v,
                                                input logic rs_vld, input logic [ROB_W-1:0] rs_id,
                                                input logic [DATA_W-1:0] rs_data,
                                                input logic ls_vld, input logic [ROB_W-1:0] ls_id,
                                                input logic [DATA_W-1:0] ls_data);
    if (bus_hit(tag, rs_vld, rs_id))      return rs_data;
    else if (bus_hit(tag, ls_vld, ls_id)) return ls_data;
    else                                  return v;
  endfunction

  function automatic logic [ROB_W-1:0] fwd_tag(input logic [ROB_W-1:0] tag,
                                               input logic rs_vld, input logic [ROB_W-1:0] rs_id,
                                               input logic ls_vld, input logic [ROB_W-1:0] ls_id);
    if (bus_hit(tag, rs_vld, rs_id) || bus_hit(tag, ls_vld, ls_id)) return '0;
    else return tag;
  endfunction

  // Selection from pre-edge state: descending scan leaves the lowest index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    busy_cnt   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && (q1[i] == '0) && (q2[i] == '0)) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + CNT_W'(busy[i]);
  end

  assign full_sign_to_fch = (busy_cnt >= CNT_W'(RS_SIZE - 1));
  assign advance          = rdy && !rollback_sign_from_rob;
  assign do_insert        = advance && enable_sign_from_cmd && free_found;

  // Control stage: busy bits, operand tags and the registered issue port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy                 <= '0;
      enable_sign_to_rs_ex <= 1'b0;
      opnum_to_rs_ex       <= '0;
      V1_to_rs_ex          <= '0;
      V2_to_rs_ex          <= '0;
      pc_to_rs_ex          <= '0;
      imm_to_rs_ex         <= '0;
      rob_id_to_rs_ex      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        q1[i] <= '0;
        q2[i] <= '0;
      end
    end else if (rdy) begin
      if (rollback_sign_from_rob) begin
        busy                 <= '0;
        enable_sign_to_rs_ex <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            q1[i] <= fwd_tag(q1[i], valid_sign_from_rs_ex, rob_id_from_rs_ex,
                             valid_sign_from_ls_ex, rob_id_from_ls_ex);
            q2[i] <= fwd_tag(q2[i], valid_sign_from_rs_ex, rob_id_from_rs_ex,
                             valid_sign_from_ls_ex, rob_id_from_ls_ex);
          end
        end
        enable_sign_to_rs_ex <= iss_found;
        if (iss_found) begin
          busy[iss_idx]   <= 1'b0;
          opnum_to_rs_ex  <= op[iss_idx];
          V1_to_rs_ex     <= v1[iss_idx];
          V2_to_rs_ex     <= v2[iss_idx];
          pc_to_rs_ex     <= pc[iss_idx];
          imm_to_rs_ex    <= imm[iss_idx];
          rob_id_to_rs_ex <= rob[iss_idx];
        end
        if (do_insert) begin
          busy[free_idx] <= 1'b1;
          q1[free_idx]   <= fwd_tag(Q1_from_cmd, valid_sign_from_rs_ex, rob_id_from_rs_ex,
                                    valid_sign_from_ls_ex, rob_id_from_ls_ex);
          q2[free_idx]   <= fwd_tag(Q2_from_cmd, valid_sign_from_rs_ex, rob_id_from_rs_ex,
                                    valid_sign_from_ls_ex, rob_id_from_ls_ex);
        end
      end
    end
  end

  // Data stage: operand values and instruction fields, never reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          v1[i] <= fwd_val(q1[i], v1[i], valid_sign_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex,
                           valid_sign_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex);
          v2[i] <= fwd_val(q2[i], v2[i], valid_sign_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex,
                           valid_sign_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex);
        end
      end
      if (do_insert) begin
        op[free_idx]  <= opnum_from_cmd;
        pc[free_idx]  <= pc_from_cmd;
        imm[free_idx] <= imm_from_cmd;
        rob[free_idx] <= rob_id_from_cmd;
        v1[free_idx]  <= fwd_val(Q1_from_cmd, V1_from_cmd, valid_sign_from_rs_ex, rob_id_from_rs_ex,
                                 data_from_rs_ex, valid_sign_from_ls_ex, rob_id_from_ls_ex,
                                 data_from_ls_ex);
        v2[free_idx]  <= fwd_val(Q2_from_cmd, V2_from_cmd, valid_sign_from_rs_ex, rob_id_from_rs_ex,
                                 data_from_rs_ex, valid_sign_from_ls_ex, rob_id_from_ls_ex,
                                 data_from_ls_ex);
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: latency, wakeup/bypass priority, fill and
// drain order, rollback, stall freeze and asynchronous reset.
module tb_reservation_station;

  localparam int RS_SIZE = 16;
  localparam int ROB_W   = 5;
  localparam int OP_W    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             enable_sign_from_cmd;
  logic [OP_W-1:0]  opnum_from_cmd;
  logic [31:0]      V1_from_cmd, V2_from_cmd;
  logic [ROB_W-1:0] Q1_from_cmd, Q2_from_cmd;
  logic [31:0]      pc_from_cmd, imm_from_cmd;
  logic [ROB_W-1:0] rob_id_from_cmd;
  logic             valid_sign_from_rs_ex;
  logic [ROB_W-1:0] rob_id_from_rs_ex;
  logic [31:0]      data_from_rs_ex;
  logic             valid_sign_from_ls_ex;
  logic [ROB_W-1:0] rob_id_from_ls_ex;
  logic [31:0]      data_from_ls_ex;
  logic             rollback_sign_from_rob;
  logic             full_sign_to_fch;
  logic             enable_sign_to_rs_ex;
  logic [OP_W-1:0]  opnum_to_rs_ex;
  logic [31:0]      V1_to_rs_ex, V2_to_rs_ex, pc_to_rs_ex, imm_to_rs_ex;
  logic [ROB_W-1:0] rob_id_to_rs_ex;

  int n_chk = 0;
  int n_err = 0;

  reservation_station #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_sign_from_cmd(enable_sign_from_cmd), .opnum_from_cmd(opnum_from_cmd),
    .V1_from_cmd(V1_from_cmd), .V2_from_cmd(V2_from_cmd),
    .Q1_from_cmd(Q1_from_cmd), .Q2_from_cmd(Q2_from_cmd),
    .pc_from_cmd(pc_from_cmd), .imm_from_cmd(imm_from_cmd), .rob_id_from_cmd(rob_id_from_cmd),
    .valid_sign_from_rs_ex(valid_sign_from_rs_ex), .rob_id_from_rs_ex(rob_id_from_rs_ex),
    .data_from_rs_ex(data_from_rs_ex),
    .valid_sign_from_ls_ex(valid_sign_from_ls_ex), .rob_id_from_ls_ex(rob_id_from_ls_ex),
    .data_from_ls_ex(data_from_ls_ex),
    .rollback_sign_from_rob(rollback_sign_from_rob), .full_sign_to_fch(full_sign_to_fch),
    .enable_sign_to_rs_ex(enable_sign_to_rs_ex), .opnum_to_rs_ex(opnum_to_rs_ex),
    .V1_to_rs_ex(V1_to_rs_ex), .V2_to_rs_ex(V2_to_rs_ex),
    .pc_to_rs_ex(pc_to_rs_ex), .imm_to_rs_ex(imm_to_rs_ex), .rob_id_to_rs_ex(rob_id_to_rs_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [ROB_W-1:0] q1, input logic [ROB_W-1:0] q2,
                      input logic [ROB_W-1:0] rob);
    enable_sign_from_cmd = 1'b1;
    opnum_from_cmd       = op;
    V1_from_cmd          = v1;
    V2_from_cmd          = v2;
    Q1_from_cmd          = q1;
    Q2_from_cmd          = q2;
    pc_from_cmd          = 32'h1000 + 32'(rob);
    imm_from_cmd         = 32'h20 + 32'(rob);
    rob_id_from_cmd      = rob;
  endtask

  task automatic rs_bcast(input logic [ROB_W-1:0] id, input logic [31:0] d);
    valid_sign_from_rs_ex = 1'b1;
    rob_id_from_rs_ex     = id;
    data_from_rs_ex       = d;
  endtask

  task automatic ls_bcast(input logic [ROB_W-1:0] id, input logic [31:0] d);
    valid_sign_from_ls_ex = 1'b1;
    rob_id_from_ls_ex     = id;
    data_from_ls_ex       = d;
  endtask

  task automatic idle();
    enable_sign_from_cmd  = 1'b0;
    valid_sign_from_rs_ex = 1'b0;
    valid_sign_from_ls_ex = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback_sign_from_rob = 1'b0;
    opnum_from_cmd = '0; V1_from_cmd = '0; V2_from_cmd = '0; Q1_from_cmd = '0; Q2_from_cmd = '0;
    pc_from_cmd = '0; imm_from_cmd = '0; rob_id_from_cmd = '0;
    rob_id_from_rs_ex = '0; data_from_rs_ex = '0; rob_id_from_ls_ex = '0; data_from_ls_ex = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_enable", enable_sign_to_rs_ex, 0);
    chk("reset_full", full_sign_to_fch, 0);
    chk("reset_rob_id", rob_id_to_rs_ex, 0);
    chk("reset_v1", V1_to_rs_ex, 0);
    rst = 1'b1;
    step();

    // Ready-on-arrival ADD: issued one edge after insert, one-cycle enable.
    disp(6'd1, 32'd3, 32'd4, 0, 0, 5'd7);
    step();
    idle();
    chk("add_not_early", enable_sign_to_rs_ex, 0);
    step();
    chk("add_enable", enable_sign_to_rs_ex, 1);
    chk("add_v1", V1_to_rs_ex, 3);
    chk("add_v2", V2_to_rs_ex, 4);
    chk("add_rob", rob_id_to_rs_ex, 7);
    chk("add_op", opnum_to_rs_ex, 1);
    chk("add_pc", pc_to_rs_ex, 32'h1007);
    chk("add_imm", imm_to_rs_ex, 32'h27);
    step();
    chk("add_enable_drop", enable_sign_to_rs_ex, 0);
    chk("add_v1_hold", V1_to_rs_ex, 3);

    // Wakeup with both buses on the same tag: ALU data must win.
    disp(6'd2, 32'd0, 32'd2, 5'd5, 0, 5'd8);
    step();
    idle();
    step();
    chk("wake_pending", enable_sign_to_rs_ex, 0);
    rs_bcast(5'd5, 32'h55);
    ls_bcast(5'd5, 32'hAA);
    step();
    idle();
    chk("wake_not_early", enable_sign_to_rs_ex, 0);
    step();
    chk("wake_enable", enable_sign_to_rs_ex, 1);
    chk("wake_v1_prio", V1_to_rs_ex, 32'h55);
    chk("wake_v2", V2_to_rs_ex, 2);
    chk("wake_rob", rob_id_to_rs_ex, 8);
    step();

    // Insert bypass from the load bus.
    disp(6'd3, 32'd0, 32'd1, 5'd9, 0, 5'd10);
    ls_bcast(5'd9, 32'h1234);
    step();
    idle();
    step();
    chk("bypass_enable", enable_sign_to_rs_ex, 1);
    chk("bypass_v1", V1_to_rs_ex, 32'h1234);
    chk("bypass_rob", rob_id_to_rs_ex, 10);
    step();

    // Broadcast rob id 0 must not touch an operand whose tag is 0.
    disp(6'd4, 32'h11, 32'h22, 0, 0, 5'd11);
    rs_bcast(5'd0, 32'hFF);
    step();
    enable_sign_from_cmd = 1'b0;
    step();
    idle();
    chk("rob0_enable", enable_sign_to_rs_ex, 1);
    chk("rob0_v1", V1_to_rs_ex, 32'h11);
    chk("rob0_v2", V2_to_rs_ex, 32'h22);
    step();

    // Fill 15 entries on tag 3, then drain in index order after one broadcast.
    for (int i = 0; i < 15; i++) begin
      disp(6'd5, 32'(i), 32'd0, 5'd3, 0, 5'(16 + i));
      step();
      chk("fill_full", full_sign_to_fch, (i == 14) ? 1 : 0);
    end
    idle();
    chk("fill_no_issue", enable_sign_to_rs_ex, 0);
    rs_bcast(5'd3, 32'h33);
    step();
    idle();
    chk("drain_not_early", enable_sign_to_rs_ex, 0);
    chk("drain_full_before", full_sign_to_fch, 1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("drain_enable", enable_sign_to_rs_ex, 1);
      chk("drain_rob_order", rob_id_to_rs_ex, 16 + i);
      chk("drain_v1", V1_to_rs_ex, 32'h33);
      chk("drain_full", full_sign_to_fch, 0);
    end
    step();
    chk("drain_done", enable_sign_to_rs_ex, 0);

    // Rollback with a simultaneous dispatch clears everything.
    for (int i = 0; i < 4; i++) begin
      disp(6'd6, 32'd0, 32'd0, 5'd6, 0, 5'(1 + i));
      step();
    end
    disp(6'd7, 32'd0, 32'd0, 0, 0, 5'd20);
    rollback_sign_from_rob = 1'b1;
    step();
    rollback_sign_from_rob = 1'b0;
    idle();
    chk("rb_enable", enable_sign_to_rs_ex, 0);
    rs_bcast(5'd6, 32'h66);
    step();
    idle();
    chk("rb_dropped_dispatch", enable_sign_to_rs_ex, 0);
    step();
    chk("rb_no_wakeup_issue", enable_sign_to_rs_ex, 0);
    disp(6'd8, 32'd0, 32'd0, 0, 0, 5'd21);
    step();
    idle();
    step();
    chk("rb_next_enable", enable_sign_to_rs_ex, 1);
    chk("rb_next_rob", rob_id_to_rs_ex, 21);
    step();

    // Stall: a ready entry waits while rdy is low; rollback and dispatch ignored.
    disp(6'd9, 32'h77, 32'd0, 0, 0, 5'd25);
    step();
    rdy = 1'b0;
    disp(6'd9, 32'd0, 32'd0, 0, 0, 5'd26);
    rs_bcast(5'd25, 32'h99);
    rollback_sign_from_rob = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_enable", enable_sign_to_rs_ex, 0);
      chk("stall_rob_hold", rob_id_to_rs_ex, 21);
    end
    rdy = 1'b1;
    rollback_sign_from_rob = 1'b0;
    idle();
    step();
    chk("stall_release_enable", enable_sign_to_rs_ex, 1);
    chk("stall_release_rob", rob_id_to_rs_ex, 25);
    chk("stall_release_v1", V1_to_rs_ex, 32'h77);
    rdy = 1'b0;
    step();
    chk("stall_enable_held", enable_sign_to_rs_ex, 1);
    rdy = 1'b1;
    step();
    chk("stall_no_extra", enable_sign_to_rs_ex, 0);

    // Asynchronous reset mid-operation with the station nearly full.
    for (int i = 0; i < 15; i++) begin
      disp(6'd10, 32'd0, 32'd0, 5'd12, 0, 5'(i));
      step();
    end
    idle();
    chk("areset_pre_full", full_sign_to_fch, 1);
    #2 rst = 1'b0;
    #1;
    chk("areset_full", full_sign_to_fch, 0);
    chk("areset_rob", rob_id_to_rs_ex, 0);
    chk("areset_v1", V1_to_rs_ex, 0);
    step();
    rst = 1'b1;
    disp(6'd11, 32'd5, 32'd6, 0, 0, 5'd30);
    step();
    idle();
    step();
    chk("areset_after_enable", enable_sign_to_rs_ex, 1);
    chk("areset_after_rob", rob_id_to_rs_ex, 30);
    chk("areset_after_v1", V1_to_rs_ex, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
